// File: rtl/gcu_pkg.sv
// gcu_pkg: shared node scheduler types and default sizes
package gcu_pkg;
  localparam int NODE_ID_W = 4;
  localparam int MAX_NODES = 16;
  localparam int CNT_W = NODE_ID_W + 1;
  typedef enum logic [2:0] {IDLE, QUERY, WAIT_RSP, DISPATCH, DRAIN, DONE} sched_state_e;
endpackage

// File: rtl/gcu_node_scheduler_if.sv
// gcu_node_scheduler_if: scoreboard query, executor dispatch/completion and scatter-done channels
// master = scheduler side, slave = scoreboard/executor side
interface gcu_node_scheduler_if import gcu_pkg::*; #(parameter int NODE_ID_W = gcu_pkg::NODE_ID_W);
  logic query_valid;
  logic [NODE_ID_W-1:0] query_node_id;
  logic front_ready;
  logic dispatch_valid;
  logic [NODE_ID_W-1:0] dispatch_node_id;
  logic dispatch_ready;
  logic comp_valid;
  logic comp_has_parent;
  logic [NODE_ID_W-1:0] comp_parent_id;
  logic [NODE_ID_W-1:0] comp_node_id;
  logic scatter_done_valid;
  logic [NODE_ID_W-1:0] scatter_done_child_id;
  logic [NODE_ID_W-1:0] scatter_done_parent_id;
  modport master(
    output query_valid, query_node_id, dispatch_valid, dispatch_node_id,
    output scatter_done_valid, scatter_done_child_id, scatter_done_parent_id,
    input front_ready, dispatch_ready, comp_valid, comp_has_parent, comp_parent_id, comp_node_id
  );
  modport slave(
    input query_valid, query_node_id, dispatch_valid, dispatch_node_id,
    input scatter_done_valid, scatter_done_child_id, scatter_done_parent_id,
    output front_ready, dispatch_ready, comp_valid, comp_has_parent, comp_parent_id, comp_node_id
  );
endinterface

// File: rtl/gcu_sched_scatter_fwd.sv
// gcu_sched_scatter_fwd: registers completions into scatter-done events plus a one-cycle delayed valid
// fire/child/parent in; vld, vld_dly, child_o, parent_o out
module gcu_sched_scatter_fwd import gcu_pkg::*; #(parameter int NODE_ID_W = gcu_pkg::NODE_ID_W) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fire,
  input  logic [NODE_ID_W-1:0] child,
  input  logic [NODE_ID_W-1:0] parent,
  output logic                 vld,
  output logic                 vld_dly,
  output logic [NODE_ID_W-1:0] child_o,
  output logic [NODE_ID_W-1:0] parent_o
);
  logic vld_q, vld_d, dly_q, dly_d;
  logic [NODE_ID_W-1:0] child_q, child_d, parent_q, parent_d;
  always_comb begin
    vld_d = fire;
    dly_d = vld_q;
    child_d = fire ? child : child_q;
    parent_d = fire ? parent : parent_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= 1'b0;
      dly_q <= 1'b0;
      child_q <= '0;
      parent_q <= '0;
    end else begin
      vld_q <= vld_d;
      dly_q <= dly_d;
      child_q <= child_d;
      parent_q <= parent_d;
    end
  assign vld = vld_q;
  assign vld_dly = dly_q;
  assign child_o = child_q;
  assign parent_o = parent_q;
endmodule

// File: rtl/gcu_node_scheduler.sv
// gcu_node_scheduler: round-robin dispatch of ready task-graph nodes with completion and deadlock detection
// start/start_num_nodes in; busy/sched_done/sched_err out; bus = query, dispatch, completion, scatter-done
module gcu_node_scheduler import gcu_pkg::*; #(
  parameter int NODE_ID_W = gcu_pkg::NODE_ID_W,
  parameter int MAX_NODES = gcu_pkg::MAX_NODES,
  parameter int CNT_W = NODE_ID_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     start_num_nodes,
  output logic                 busy,
  output logic                 sched_done,
  output logic                 sched_err,
  gcu_node_scheduler_if.master bus
);
  sched_state_e state_q, state_d;
  logic [CNT_W-1:0] ptr_q, ptr_d, num_q, num_d, issued_q, issued_d, comp_q, comp_d, miss_q, miss_d;
  logic [MAX_NODES-1:0] disp_q, disp_d;
  logic err_q, err_d, done_q, done_d;
  logic sd_vld, sd_dly, settle, dead;
  logic [NODE_ID_W-1:0] idx;
  logic [CNT_W-1:0] ptr_nxt, clamp, miss_inc;
  assign idx = ptr_q[NODE_ID_W-1:0];
  assign ptr_nxt = (ptr_q == num_q - CNT_W'(1)) ? '0 : ptr_q + CNT_W'(1);
  assign clamp = (start_num_nodes > CNT_W'(MAX_NODES)) ? CNT_W'(MAX_NODES) : start_num_nodes;
  assign miss_inc = miss_q + CNT_W'(1);
  // scoreboard counts may still be settling while a completion or its scatter event is in flight
  assign settle = bus.comp_valid | sd_vld | sd_dly;
  assign dead = !settle && (miss_inc >= num_q - issued_q) && (issued_q == comp_q);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    num_d = num_q;
    issued_d = issued_q;
    comp_d = comp_q + CNT_W'(busy && bus.comp_valid && state_q != DONE);
    miss_d = miss_q;
    disp_d = disp_q;
    err_d = err_q;
    done_d = state_q == DONE;
    unique case (state_q)
      IDLE: if (start) begin
        num_d = clamp;
        ptr_d = '0;
        issued_d = '0;
        comp_d = '0;
        miss_d = '0;
        disp_d = '0;
        err_d = 1'b0;
        state_d = (clamp == '0) ? DONE : QUERY;
      end
      QUERY: if (disp_q[idx]) ptr_d = ptr_nxt;
        else state_d = WAIT_RSP;
      WAIT_RSP: if (bus.front_ready) state_d = DISPATCH;
        else begin
          ptr_d = ptr_nxt;
          miss_d = miss_inc;
          err_d = dead;
          state_d = dead ? DONE : QUERY;
        end
      DISPATCH: if (bus.dispatch_ready) begin
        disp_d[idx] = 1'b1;
        issued_d = issued_q + CNT_W'(1);
        miss_d = '0;
        ptr_d = ptr_nxt;
        state_d = (issued_q + CNT_W'(1) == num_q) ? DRAIN : QUERY;
      end
      DRAIN: if (comp_q == num_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (settle && state_q != IDLE) miss_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      num_q <= '0;
      issued_q <= '0;
      comp_q <= '0;
      miss_q <= '0;
      disp_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      num_q <= num_d;
      issued_q <= issued_d;
      comp_q <= comp_d;
      miss_q <= miss_d;
      disp_q <= disp_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  assign busy = state_q != IDLE;
  assign sched_done = done_q;
  assign sched_err = err_q;
  assign bus.query_valid = state_q == QUERY && !disp_q[idx];
  assign bus.query_node_id = idx;
  assign bus.dispatch_valid = state_q == DISPATCH;
  assign bus.dispatch_node_id = idx;
  gcu_sched_scatter_fwd #(.NODE_ID_W(NODE_ID_W)) u_fwd (
    .clk(clk),
    .rst_n(rst_n),
    .fire(busy && bus.comp_valid && bus.comp_has_parent),
    .child(bus.comp_node_id),
    .parent(bus.comp_parent_id),
    .vld(sd_vld),
    .vld_dly(sd_dly),
    .child_o(bus.scatter_done_child_id),
    .parent_o(bus.scatter_done_parent_id)
  );
  assign bus.scatter_done_valid = sd_vld;
endmodule

// File: doc/gcu_node_scheduler.md
# gcu_node_scheduler

Dispatch scheduler for the GCU task graph: scans node IDs round-robin, queries the dependency scoreboard for `front_ready`, and issues each ready node exactly once to the node executor over a valid/ready handshake. It forwards executor completions to the scoreboard as scatter-done events, detects run completion and deadlock, and sits between the GCU top-level control, the dependency scoreboard and the executor.

## Interface
- `NODE_ID_W`, 4, node ID width
- `MAX_NODES`, 16, node table depth (≤ 2^NODE_ID_W)
- `CNT_W`, NODE_ID_W+1, width of node counters (holds MAX_NODES)

- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  run-start pulse; sampled only in IDLE
- `start_num_nodes`  in  CNT_W  node count for the run, 0..MAX_NODES; values > MAX_NODES are clamped to MAX_NODES
- `busy`  out  1  high in every state except IDLE
- `sched_done`  out  1  one-cycle pulse at end of run
- `sched_err`  out  1  deadlock flag, valid with `sched_done`, held until next accepted `start`
- `query_valid`  out  1  scoreboard query strobe
- `query_node_id`  out  NODE_ID_W  queried node
- `front_ready`  in  1  scoreboard response, one cycle after the query
- `dispatch_valid`  out  1  node offered to the executor
- `dispatch_node_id`  out  NODE_ID_W  offered node
- `dispatch_ready`  in  1  executor accepts
- `comp_valid`  in  1  executor finished a node
- `comp_has_parent`  in  1  node has a parent to notify
- `comp_parent_id`  in  NODE_ID_W  parent of the completed node
- `comp_node_id`  in  NODE_ID_W  completed node
- `scatter_done_valid`  out  1  to the scoreboard decrement port
- `scatter_done_child_id`, `scatter_done_parent_id`  out  NODE_ID_W each  registered copies of the completion fields

## Operation
- State registers: `ptr`, `num_nodes`, `issued_cnt`, `comp_cnt`, `miss_cnt` (all CNT_W), and a `dispatched[MAX_NODES]` bitmap.
- **IDLE**
  - On `start`: latch the clamped `num_nodes`, clear the bitmap, `ptr`, all counters and `sched_err`.
  - If `num_nodes==0`, go to DONE; otherwise go to QUERY.
- **QUERY**
  - If `dispatched[ptr]`: advance `ptr` and stay in QUERY (no query issued).
  - Otherwise: `query_valid=1`, `query_node_id=ptr`, go to WAIT_RSP.
- **WAIT_RSP**: sample `front_ready`.
  - If 1: go to DISPATCH.
  - If 0: advance `ptr`, increment `miss_cnt`, go to QUERY.
  - Deadlock check: if the incremented `miss_cnt` ≥ `num_nodes-issued_cnt` and `issued_cnt==comp_cnt`, set `sched_err` and go to DONE.
- **DISPATCH**
  - `dispatch_valid=1`, `dispatch_node_id=ptr`, both held stable until `dispatch_ready`.
  - On handshake: set `dispatched[ptr]`, `issued_cnt++`, clear `miss_cnt`, advance `ptr`.
  - Then go to DRAIN if `issued_cnt+1==num_nodes`, else go to QUERY.
- **DRAIN**: wait until `comp_cnt==num_nodes`, then go to DONE.
- **DONE**: pulse `sched_done` for one cycle, go to IDLE.
- Pointer advance: `ptr` wraps from `num_nodes-1` to 0.
- Completion: any cycle with `busy && comp_valid` increments `comp_cnt`. `comp_valid` in IDLE is ignored.
- Scatter forwarding:
  - When `busy && comp_valid && comp_has_parent`, `scatter_done_*` is registered and `scatter_done_valid` pulses the next cycle.
  - Completions without a parent are counted only.
- Miss-counter settle: `miss_cnt` is also cleared in any cycle where `comp_valid`, `scatter_done_valid`, or `scatter_done_valid` delayed by one cycle is high. This covers the scoreboard update and query latency.
- Completions arriving in DONE are still forwarded to the scoreboard; they are not counted.

## Timing
- Reset values: state IDLE; `busy`, `sched_done`, `sched_err`, `query_valid`, `dispatch_valid`, `scatter_done_valid` all 0; all IDs 0; bitmap and counters 0.
- `query_valid`, `query_node_id`, `dispatch_valid` and `dispatch_node_id` are decoded from registered state only, with no input-to-output combinational path.
- Ready-node latency: QUERY → WAIT_RSP → DISPATCH gives a minimum of 3 cycles from query to handshake. Each already-dispatched slot skipped costs 1 cycle.
- The dispatch handshake completes in the cycle where `dispatch_valid && dispatch_ready`; zero-wait acceptance is supported.
- `comp_valid` in the same cycle as a dispatch handshake: both counters update.
- A query racing a scatter update may see the stale value; the node is simply retried on the next pass.
- Asserting `rst_n` mid-run aborts immediately to reset values; no `sched_done` is issued.

## Structure
- `gcu_pkg` holds the `sched_state_e` enum (IDLE, QUERY, WAIT_RSP, DISPATCH, DRAIN, DONE) and the shared `NODE_ID_W`/`MAX_NODES` defaults.
- One natural sub-module: `gcu_sched_scatter_fwd`, which contains the completion register stage plus the one-cycle-delayed valid used for the miss-clear window.

## Test plan
- All nodes independent (scoreboard counts 0), `num_nodes=4`, `dispatch_ready=1` → dispatches 0,1,2,3 in order, each 3 cycles apart; `sched_done` after 4 completions; `sched_err=0`.
- Chain 0←1←2 (node 0 has 1 child, node 1 has 1 child, node 2 has none) → node 2 dispatched first. Completion of 2 with parent 1 gives `scatter_done_valid` next cycle; node 1 is dispatched only after the scoreboard clears, then node 0; order 2,1,0.
- Backpressure: hold `dispatch_ready=0` for 5 cycles → `dispatch_valid` and ID stable for all 5 cycles; no new `query_valid`.
- Deadlock: node 0 initialized with 1 child, `num_nodes=1`, no completions → `sched_done` with `sched_err=1` after 1 miss.
- `num_nodes=0` → `sched_done` 2 cycles after `start`, with no query or dispatch issued.
- Reset asserted in DISPATCH → all outputs 0 in the same cycle; a new `start` runs cleanly with the bitmap cleared.
